uart_recv: RTL and testbench
============================

# uart_recv

UART 8N1 receiver that converts the serial RX pin into one-cycle byte strobes. It sits directly upstream of `string_match` and drives that block's `valid` and `recv_data` inputs. It synchronises the asynchronous line, qualifies the start bit, samples each bit at mid-bit, checks the stop bit, and delivers only correctly framed bytes.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived constant `DIV = CLK_FREQ/BAUD` (10416 at the defaults).
- Derived constant `HALF = DIV/2` (5208 at the defaults).
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `din`  in  1  serial RX line, asynchronous to `clk`; idles high.
- `valid`  out  1  one-cycle pulse: `data` holds a new, correctly framed byte.
- `data`  out  8  last good byte received; updated only together with `valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input synchronisation:** `din` passes through a 2-flop synchroniser, giving `rx_s`. The synchroniser flops reset to 1. All logic below uses `rx_s`.
- **Counter:** `cnt` is a `$clog2(DIV)`-bit counter; it restarts at 0 on every state change. `bit_idx` is a 3-bit counter. A shift register is loaded LSB first.
- **IDLE:**
  - `rx_s==0` → START, with `cnt` = 0.
  - Otherwise stay.
- **START:** `cnt` increments each cycle. At `cnt==HALF-1`, sample `rx_s`:
  - 0 → DATA, with `cnt` = 0 and `bit_idx` = 0.
  - 1 → IDLE. This is a glitch/false start: no output, no error.
- **DATA:** At `cnt==DIV-1`:
  - Shift `rx_s` into bit 7 of the shift register (right shift, so the first bit ends in bit 0).
  - `cnt` = 0 and `bit_idx` increments.
  - After the sample with `bit_idx==7` → STOP.
- **STOP:** At `cnt==DIV-1`, sample `rx_s`:
  - 1 → `data` takes the shift register, `valid` = 1 for one cycle, → IDLE.
  - 0 → `frame_err` = 1 for one cycle, `data` unchanged, → BREAK.
- **BREAK:**
  - Stay while `rx_s==0`. A held-low line produces exactly one `frame_err`.
  - `rx_s==1` → IDLE.
- **Unused state encodings:** → IDLE.
- **Reset values:**
  - `valid` = 0, `frame_err` = 0, `busy` = 0, `data` = 8'h00.
  - State = IDLE; counters = 0.
- **Reset mid-frame:** the partial byte is discarded and nothing is pulsed. The first falling edge after reset release starts a fresh frame.
- **No flow control:** there is no backpressure. The consumer must accept `valid` in the same cycle it is high.
- **Exclusivity:** `valid` and `frame_err` are never high in the same cycle.

## Timing
- **Reference point:** t0 is the first cycle in which `rx_s==0` while in IDLE. `rx_s` lags `din` by 2 clocks.
- **Start sample:** t0+1+HALF-1 = t0+HALF.
- **Data bit i (i = 0..7):** sampled at t0+HALF+(i+1)·DIV.
- **Stop sample:** t0+HALF+9·DIV, which is t0+98952 at the defaults.
- **Outputs after the stop sample:** `valid` or `frame_err` is registered and high in the next cycle, t0+HALF+9·DIV+1. `data` changes in that same cycle.
- **Back-to-back frames:** the block is in IDLE by mid-stop-bit. The next start edge is accepted with no dead time.
- **Tolerance:** at least ±2% baud mismatch accumulated over 10 bits, because sampling is at mid-bit.
- **`busy` timing:** rises the cycle after t0 and falls the cycle after leaving STOP/BREAK to IDLE.

## Structure
- **Shared header `uart_defs.vh`:**
  - Default `CLK_FREQ`/`BAUD`.
  - `DIV`/`HALF` computation.
  - Line idle level.
  - This header is also used by `uart_send`, so both ends share one baud definition.
- **Local to this block:** the state encoding localparams (IDLE, START, DATA, STOP, BREAK, as 3 bits).
- **Sub-module:** `sync_2ff`, a generic 1-bit two-flop synchroniser with reset value parameter `INIT`. It is reused for the button/switch inputs.
- **Top-level wiring:** `uart_recv.valid`/`data` connect directly to `string_match.valid`/`recv_data`.

## Test plan
1. **Good frame:** idle line, then send 8'h73 (`s`) at 9600 baud → exactly one `valid` pulse; `data` = 8'h73 at t0+98953; `frame_err` stays 0.
2. **Back-to-back frames:** send `S`,`T`,`O`,`P`,CR (8'h53, 8'h54, 8'h4F, 8'h50, 8'h0D) with no idle gap → five `valid` pulses, each exactly 10·DIV apart, carrying those bytes in order.
3. **Glitch rejection:** drive `din` low for 3000 cycles (< HALF), then high → no `valid`, no `frame_err`; `busy` returns to 0; a following byte 8'h68 is received correctly.
4. **Framing error:** send 8'h55 with stop bit 0, after a prior good byte 8'h41 → one `frame_err` pulse; no `valid`; `data` stays 8'h41. Hold the line low for a further 5·DIV → no additional pulses. Release, then send 8'h7A → `valid` with `data` = 8'h7A.
5. **Reset mid-frame:** assert `rst` during data bit 4 of 8'hFF → all outputs 0 immediately; no pulse when the interrupted frame ends. After release, 8'h0A is received correctly.
6. **Baud offset:** send 8'hA5 with bit period DIV·1.02 and then DIV·0.98 → `valid` with `data` = 8'hA5 in both cases.

Source files
------------

// File: rtl/uart_recv_pkg.sv
// Shared UART definitions: default line rate, divider helper, idle level and receiver states.
package uart_recv_pkg;

  localparam int unsigned DefClkFreq = 100_000_000;
  localparam int unsigned DefBaud    = 9600;
  localparam logic        LineIdle   = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs, with selectable reset value.
module sync_2ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{INIT}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_recv.sv
// UART 8N1 receiver: mid-bit sampling, stop-bit check, one-cycle strobes for good bytes
// and framing errors.
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefClkFreq,
  parameter int unsigned BAUD     = DefBaud
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = $clog2(Div);

  localparam logic [CntW-1:0] CntHalfEnd = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(Div - 1);

  logic rx_s;

  sync_2ff #(
    .INIT (LineIdle)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (rx_s)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalfEnd) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            // False start: line went back high before mid start bit.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        // A held-low line reports one error only; wait here until it idles.
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign data      = data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv, run at a reduced clock/baud ratio (DIV=50, HALF=25).
module tb_uart_recv;

  localparam int unsigned ClkFreq = 5_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int          Div     = 50;
  localparam int          Half    = 25;
  // din fall -> valid: 2 sync cycles + t0 offset of HALF+9*DIV+1.
  localparam int          Latency = 2 + Half + 9 * Div + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] data;

  uart_recv #(
    .CLK_FREQ (ClkFreq),
    .BAUD     (Baud)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0;
  int         n_ferr = 0;
  bit         both_seen = 1'b0;
  logic [7:0] vq[$];
  int         cq[$];

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      cq.push_back(cyc);
      vq.push_back(data);
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) both_seen = 1'b1;
  end

  int total = 0;
  int bad = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int per, input int hold);
    din = 1'b0;
    fall_cyc = cyc;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      tick(per);
    end
    din = stop;
    tick(per);
    if (!stop) tick(hold);
    din = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         per;
    int         hold;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] b2b[5];
  int         bv, bf, bq;

  initial begin
    vecs[0] = '{8'h73, 1'b1, Div,     0,       1, 0, 8'h73};
    vecs[1] = '{8'h41, 1'b1, Div,     0,       1, 0, 8'h41};
    vecs[2] = '{8'h55, 1'b0, Div,     5 * Div, 0, 1, 8'h41};
    vecs[3] = '{8'h7A, 1'b1, Div,     0,       1, 0, 8'h7A};
    vecs[4] = '{8'hA5, 1'b1, Div + 1, 0,       1, 0, 8'hA5};
    vecs[5] = '{8'hA5, 1'b1, Div - 1, 0,       1, 0, 8'hA5};
    vecs[6] = '{8'h00, 1'b1, Div,     0,       1, 0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, Div,     0,       1, 0, 8'hFF};
    b2b = '{8'h53, 8'h54, 8'h4F, 8'h50, 8'h0D};

    // Reset state
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 8'h00);
    rst = 1'b0;
    tick(5);
    check("idle_busy", busy, 0);

    // Single frames, including framing error with held-low line and baud offsets
    for (int v = 0; v < 8; v++) begin
      bv = n_valid;
      bf = n_ferr;
      bq = cq.size();
      send(vecs[v].b, vecs[v].stop, vecs[v].per, vecs[v].hold);
      tick(Div);
      check($sformatf("vec%0d_valid_cnt", v), n_valid - bv, vecs[v].exp_v);
      check($sformatf("vec%0d_ferr_cnt", v), n_ferr - bf, vecs[v].exp_f);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_d);
      check($sformatf("vec%0d_busy", v), busy, 0);
      if (vecs[v].exp_v == 1 && cq.size() > bq) begin
        check($sformatf("vec%0d_latency", v), cq[bq] - fall_cyc, Latency);
        check($sformatf("vec%0d_strobe_data", v), vq[bq], vecs[v].exp_d);
      end
    end

    // Back-to-back frames with no idle gap
    bq = cq.size();
    for (int k = 0; k < 5; k++) send(b2b[k], 1'b1, Div, 0);
    tick(Div);
    check("b2b_count", cq.size() - bq, 5);
    if (cq.size() - bq == 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("b2b_data%0d", k), vq[bq + k], b2b[k]);
        if (k > 0) check($sformatf("b2b_gap%0d", k), cq[bq + k] - cq[bq + k - 1], 10 * Div);
      end
    end

    // Glitch shorter than half a bit
    bv = n_valid;
    bf = n_ferr;
    din = 1'b0;
    tick(5);
    check("glitch_busy_hi", busy, 1);
    tick(5);
    din = 1'b1;
    tick(2 * Div);
    check("glitch_valid", n_valid - bv, 0);
    check("glitch_ferr", n_ferr - bf, 0);
    check("glitch_busy_lo", busy, 0);
    send(8'h68, 1'b1, Div, 0);
    tick(Div);
    check("post_glitch_valid", n_valid - bv, 1);
    check("post_glitch_data", data, 8'h68);

    // Reset during data bit 4 of 8'hFF
    bv = n_valid;
    bf = n_ferr;
    din = 1'b0;
    tick(Div);
    din = 1'b1;
    tick(4 * Div + Div / 2);
    rst = 1'b1;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", data, 8'h00);
    tick(3);
    rst = 1'b0;
    tick(6 * Div);
    check("midrst_no_valid", n_valid - bv, 0);
    check("midrst_no_ferr", n_ferr - bf, 0);
    send(8'h0A, 1'b1, Div, 0);
    tick(Div);
    check("post_rst_valid", n_valid - bv, 1);
    check("post_rst_data", data, 8'h0A);

    check("exclusive", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
